// File: rtl/cavlc_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cavlc_ctrl_fsm                                                 |
// | Purpose : Sequencer for one CAVLC residual block (nC, coeff_token,       |
// |           levels, total_zeros, runs, coefficient combine).               |
// | Option  : CAVLC_CTRL_ERR_CHK_EN enables TotalCoeff range and nC timeout  |
// |           error checks.                                                  |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module cavlc_ctrl_fsm #(
   parameter int ST_W       = 4,
   parameter int NC_TIMEOUT = 63
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            cavlc_start,
   input  logic [4:0]      maxNumCoeff,
   input  logic            bs_valid,
   input  logic            cavlc_nc_end,
   input  logic [4:0]      TotalCoeff,
   input  logic [1:0]      TrailingOnes,
   input  logic [3:0]      zerosLeft,
   input  logic [3:0]      run,
   output logic [ST_W-1:0] cavlc_decoder_state,
   output logic [3:0]      i_level,
   output logic [3:0]      i_run,
   output logic [3:0]      i_TotalCoeff,
   output logic [3:0]      coeffNum,
   output logic            suffix_length_initialized,
   output logic            IsRunLoop,
   output logic            cavlc_busy,
   output logic            cavlc_done,
   output logic            cavlc_err
);

   typedef enum logic [3:0] {
      ST_IDLE         = 4'd0,
      ST_NC           = 4'd1,
      ST_COEFF_TOKEN  = 4'd2,
      ST_LEVEL_PREFIX = 4'd3,
      ST_LEVEL_SUFFIX = 4'd4,
      ST_TOTAL_ZEROS  = 4'd5,
      ST_RUN          = 4'd6,
      ST_COMBINE      = 4'd7,
      ST_END          = 4'd8
   } state_t;

   state_t     r_state;
   logic [4:0] r_max;
   logic [4:0] r_tc;
   logic [3:0] r_i_level;
   logic [3:0] r_i_run;
   logic [3:0] r_i_tc;
   logic [3:0] r_coeff_num;
   logic       r_sli;
   logic       r_is_run;
   logic       r_busy;
   logic       r_done;
   logic       r_no_runs;

   logic [4:0] w_tc_now;
   logic       w_to_tz;
   logic [3:0] w_run_add;

   // TotalCoeff is only valid from the decoder at the end of COEFF_TOKEN; later use the latched copy
   assign w_tc_now  = (r_state == ST_COEFF_TOKEN) ? TotalCoeff : r_tc;
   assign w_to_tz   = (w_tc_now < r_max);
   assign w_run_add = r_no_runs ? 4'd0 : run;

`ifdef CAVLC_CTRL_ERR_CHK_EN
   localparam int NC_CW = $clog2(NC_TIMEOUT + 1);
   logic             r_err;
   logic [NC_CW-1:0] r_nc_cnt;
   assign cavlc_err = r_err;
`else
   // NC_TIMEOUT has no effect without the checker; flag tied low
   assign cavlc_err = (NC_TIMEOUT < 0);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_max       <= 5'd0;
         r_tc        <= 5'd0;
         r_i_level   <= 4'd0;
         r_i_run     <= 4'd0;
         r_i_tc      <= 4'd0;
         r_coeff_num <= 4'd0;
         r_sli       <= 1'b0;
         r_is_run    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_no_runs   <= 1'b0;
`ifdef CAVLC_CTRL_ERR_CHK_EN
         r_err       <= 1'b0;
         r_nc_cnt    <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cavlc_start) begin
                  r_max     <= maxNumCoeff;
                  r_busy    <= 1'b1;
                  r_no_runs <= 1'b0;
                  r_state   <= ST_NC;
`ifdef CAVLC_CTRL_ERR_CHK_EN
                  r_err     <= 1'b0;
                  r_nc_cnt  <= '0;
`endif
               end
            end
            ST_NC: begin
`ifdef CAVLC_CTRL_ERR_CHK_EN
               if (cavlc_nc_end) begin
                  r_state <= ST_COEFF_TOKEN;
               end else if (r_nc_cnt == NC_CW'(NC_TIMEOUT)) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_END;
               end else begin
                  r_nc_cnt <= r_nc_cnt + NC_CW'(1);
               end
`else
               if (cavlc_nc_end) r_state <= ST_COEFF_TOKEN;
`endif
            end
            ST_COEFF_TOKEN: begin
               if (bs_valid) begin
                  r_tc <= TotalCoeff;
                  if (TotalCoeff == 5'd0) begin
                     r_done  <= 1'b1;
                     r_state <= ST_END;
`ifdef CAVLC_CTRL_ERR_CHK_EN
                  end else if (TotalCoeff > r_max) begin
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= ST_END;
`endif
                  end else if (TotalCoeff == {3'b000, TrailingOnes}) begin
                     if (w_to_tz) begin
                        r_state <= ST_TOTAL_ZEROS;
                     end else begin
                        r_state     <= ST_COMBINE;
                        r_i_tc      <= w_tc_now[3:0] - 4'd1;
                        r_coeff_num <= 4'd0;
                        r_no_runs   <= 1'b1;
                     end
                  end else begin
                     r_i_level <= {2'b00, TrailingOnes};
                     r_state   <= ST_LEVEL_PREFIX;
                  end
               end
            end
            ST_LEVEL_PREFIX: begin
               if (bs_valid) r_state <= ST_LEVEL_SUFFIX;
            end
            ST_LEVEL_SUFFIX: begin
               if (bs_valid) begin
                  r_sli <= 1'b1;
                  if ({1'b0, r_i_level} == r_tc - 5'd1) begin
                     if (w_to_tz) begin
                        r_state <= ST_TOTAL_ZEROS;
                     end else begin
                        r_state     <= ST_COMBINE;
                        r_i_tc      <= w_tc_now[3:0] - 4'd1;
                        r_coeff_num <= 4'd0;
                        r_no_runs   <= 1'b1;
                     end
                  end else begin
                     r_i_level <= r_i_level + 4'd1;
                     r_state   <= ST_LEVEL_PREFIX;
                  end
               end
            end
            ST_TOTAL_ZEROS: begin
               if (bs_valid) begin
                  if (r_tc == 5'd1) begin
                     r_state     <= ST_COMBINE;
                     r_i_tc      <= 4'd0;
                     r_coeff_num <= 4'd0;
                  end else begin
                     r_state  <= ST_RUN;
                     r_i_run  <= 4'd0;
                     r_is_run <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bs_valid) begin
                  if (({1'b0, r_i_run} == r_tc - 5'd2) || (zerosLeft == 4'd0)) begin
                     r_is_run    <= 1'b0;
                     r_state     <= ST_COMBINE;
                     r_i_tc      <= r_tc[3:0] - 4'd1;
                     r_coeff_num <= 4'd0;
                  end else begin
                     r_i_run <= r_i_run + 4'd1;
                  end
               end
            end
            ST_COMBINE: begin
               r_coeff_num <= r_coeff_num + w_run_add + 4'd1;
               if (r_i_tc == 4'd0) begin
                  r_done  <= 1'b1;
                  r_state <= ST_END;
               end else begin
                  r_i_tc <= r_i_tc - 4'd1;
               end
            end
            ST_END: begin
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
               r_i_level   <= 4'd0;
               r_i_run     <= 4'd0;
               r_i_tc      <= 4'd0;
               r_coeff_num <= 4'd0;
               r_sli       <= 1'b0;
               r_is_run    <= 1'b0;
               r_no_runs   <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cavlc_decoder_state       = ST_W'(r_state);
   assign i_level                   = r_i_level;
   assign i_run                     = r_i_run;
   assign i_TotalCoeff              = r_i_tc;
   assign coeffNum                  = r_coeff_num;
   assign suffix_length_initialized = r_sli;
   assign IsRunLoop                 = r_is_run;
   assign cavlc_busy                = r_busy;
   assign cavlc_done                = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_cavlc_ctrl_fsm                                              |
// | Purpose : Self-checking bench for cavlc_ctrl_fsm; expected per-cycle     |
// |           trace is built from the block's decode parameters.            |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cavlc_ctrl_fsm;

   localparam int NC_TIMEOUT = 63;
`ifdef CAVLC_CTRL_ERR_CHK_EN
   localparam bit ERR_BUILD = 1'b1;
`else
   localparam bit ERR_BUILD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cavlc_start = 1'b0;
   logic [4:0] maxNumCoeff = 5'd0;
   logic       bs_valid = 1'b0;
   logic       cavlc_nc_end = 1'b0;
   logic [4:0] TotalCoeff = 5'd0;
   logic [1:0] TrailingOnes = 2'd0;
   logic [3:0] zerosLeft = 4'd0;
   logic [3:0] run = 4'd0;
   wire  [3:0] cavlc_decoder_state;
   wire  [3:0] i_level, i_run, i_TotalCoeff, coeffNum;
   wire        suffix_length_initialized, IsRunLoop, cavlc_busy, cavlc_done, cavlc_err;

   always #5 clk = ~clk;

   cavlc_ctrl_fsm #(.ST_W(4), .NC_TIMEOUT(NC_TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .cavlc_start(cavlc_start), .maxNumCoeff(maxNumCoeff),
      .bs_valid(bs_valid), .cavlc_nc_end(cavlc_nc_end), .TotalCoeff(TotalCoeff),
      .TrailingOnes(TrailingOnes), .zerosLeft(zerosLeft), .run(run),
      .cavlc_decoder_state(cavlc_decoder_state), .i_level(i_level), .i_run(i_run),
      .i_TotalCoeff(i_TotalCoeff), .coeffNum(coeffNum),
      .suffix_length_initialized(suffix_length_initialized), .IsRunLoop(IsRunLoop),
      .cavlc_busy(cavlc_busy), .cavlc_done(cavlc_done), .cavlc_err(cavlc_err));

   typedef struct {
      int st, lvl, irun, itc, cnum, sli, isr, err, zl, nce;
   } step_t;

   int    checks = 0;
   int    failures = 0;
   int    runs[16];
   step_t q[$];
   int    m_lvl, m_irun, m_itc, m_cnum, m_sli, m_isr, m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic push(input int st, input int zl, input int nce);
      step_t s;
      s.st = st; s.lvl = m_lvl; s.irun = m_irun; s.itc = m_itc; s.cnum = m_cnum;
      s.sli = m_sli; s.isr = m_isr; s.err = m_err; s.zl = zl; s.nce = nce;
      q.push_back(s);
   endtask

   // Expected visible trace, one entry per non-stalled cycle, from NC through the final IDLE.
   task automatic build(input int T, input int T1, input int mx, input int R,
                        input int nc_w, input bit nc_to);
      bit noruns;
      q.delete();
      m_lvl = 0; m_irun = 0; m_itc = 0; m_cnum = 0; m_sli = 0; m_isr = 0; m_err = 0;
      if (nc_to) begin
         for (int n = 0; n <= NC_TIMEOUT; n++) push(1, 0, 0);
         m_err = 1;
         push(8, 0, 0);
      end else begin
         for (int n = 0; n < nc_w; n++) push(1, 0, (n == nc_w - 1) ? 1 : 0);
         push(2, 0, 0);
         if (T == 0) begin
            push(8, 0, 0);
         end else if (ERR_BUILD && T > mx) begin
            m_err = 1;
            push(8, 0, 0);
         end else begin
            for (int L = T1; L < T; L++) begin
               m_lvl = L;
               push(3, 0, 0);
               push(4, 0, 0);
               m_sli = 1;
            end
            noruns = !(T < mx);
            if (T < mx) begin
               push(5, 0, 0);
               if (T >= 2) begin
                  m_isr = 1;
                  for (int j = 0; j < R; j++) begin
                     m_irun = j;
                     if (j < R - 1)        push(6, $urandom_range(1, 15), 0);
                     else if (R == T - 1)  push(6, $urandom_range(0, 15), 0);
                     else                  push(6, 0, 0);
                  end
                  m_isr = 0;
               end
            end
            for (int i = T - 1; i >= 0; i--) begin
               m_itc = i;
               push(7, 0, 0);
               m_cnum = (m_cnum + (noruns ? 0 : runs[i]) + 1) % 16;
            end
            push(8, 0, 0);
         end
      end
      m_lvl = 0; m_irun = 0; m_itc = 0; m_cnum = 0; m_sli = 0; m_isr = 0;
      push(0, 0, 0);
   endtask

   task automatic cmp(input int k);
      chk($sformatf("state[%0d]", k), 32'(cavlc_decoder_state), q[k].st);
      chk($sformatf("i_level[%0d]", k), 32'(i_level), q[k].lvl);
      chk($sformatf("i_run[%0d]", k), 32'(i_run), q[k].irun);
      chk($sformatf("i_TotalCoeff[%0d]", k), 32'(i_TotalCoeff), q[k].itc);
      chk($sformatf("coeffNum[%0d]", k), 32'(coeffNum), q[k].cnum);
      chk($sformatf("sli[%0d]", k), 32'(suffix_length_initialized), q[k].sli);
      chk($sformatf("IsRunLoop[%0d]", k), 32'(IsRunLoop), q[k].isr);
      chk($sformatf("busy[%0d]", k), 32'(cavlc_busy), (q[k].st != 0) ? 1 : 0);
      chk($sformatf("done[%0d]", k), 32'(cavlc_done), (q[k].st == 8) ? 1 : 0);
      chk($sformatf("err[%0d]", k), 32'(cavlc_err), q[k].err);
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_state"}, 32'(cavlc_decoder_state), 0);
      chk({pfx, "_i_level"}, 32'(i_level), 0);
      chk({pfx, "_i_run"}, 32'(i_run), 0);
      chk({pfx, "_i_TotalCoeff"}, 32'(i_TotalCoeff), 0);
      chk({pfx, "_coeffNum"}, 32'(coeffNum), 0);
      chk({pfx, "_sli"}, 32'(suffix_length_initialized), 0);
      chk({pfx, "_IsRunLoop"}, 32'(IsRunLoop), 0);
      chk({pfx, "_busy"}, 32'(cavlc_busy), 0);
      chk({pfx, "_done"}, 32'(cavlc_done), 0);
      chk({pfx, "_err"}, 32'(cavlc_err), 0);
   endtask

   // mode: 0 random bs_valid, 1 five-cycle stall in LEVEL_SUFFIX at i_level 2, 2 always valid
   task automatic run_block(input int T, input int T1, input int mx, input int R, input int nc_w,
                            input int mode, input bit nc_to, input bit rst_in_run);
      int k, cyc, stalls, busy_cyc, left, lat;
      bit bv, bitc;
      for (int i = 0; i < 16; i++) runs[i] = $urandom_range(0, 15);
      build(T, T1, mx, R, nc_w, nc_to);
      @(negedge clk);
      cavlc_start = 1'b1; maxNumCoeff = 5'(mx); TotalCoeff = 5'(T); TrailingOnes = 2'(T1);
      @(negedge clk);
      cavlc_start = 1'b0;
      k = 0; cyc = 0; stalls = 0; busy_cyc = 0; left = 5;
      while (k < q.size() && cyc < 2000) begin
         cmp(k);
         if (cavlc_busy) busy_cyc++;
         bitc = (q[k].st >= 2 && q[k].st <= 6);
         if (mode == 0)      bv = ($urandom_range(0, 3) != 0);
         else if (mode == 1) bv = !(q[k].st == 4 && q[k].lvl == 2 && left > 0);
         else                bv = 1'b1;
         if (mode == 1 && !bv) left--;
         if (bitc && !bv) stalls++;
         bs_valid     = bv;
         cavlc_nc_end = q[k].nce[0];
         zerosLeft    = 4'(q[k].zl);
         run          = 4'(runs[q[k].itc % 16]);
         cavlc_start  = (q[k].st != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         maxNumCoeff  = 5'($urandom_range(0, 16));
         if (rst_in_run && q[k].st == 6) begin
            #2 reset_n = 1'b0;
            #1 chk_zero("rst_in_run");
            @(negedge clk);
            cavlc_start = 1'b0;
            reset_n = 1'b1;
            return;
         end
         @(negedge clk);
         if (!(bitc && !bv)) k++;
         cyc++;
      end
      cavlc_start = 1'b0;
      chk("trace_complete", 32'(k), 32'(q.size()));
      if (!nc_to && !(ERR_BUILD && T > mx)) begin
         lat = nc_w + 1;
         if (T == 0) lat += 1;
         else lat += 2 * (T - T1) + ((T < mx) ? 1 + ((T >= 2) ? R : 0) : 0) + T + 1;
         chk("latency", 32'(busy_cyc), 32'(lat + stalls));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int T, T1, mx, R;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);
      run_block(0, 0, 16, 0, 2, 2, 1'b0, 1'b0);
      run_block(3, 1, 16, 2, 1, 2, 1'b0, 1'b0);
      run_block(16, 3, 16, 0, 3, 2, 1'b0, 1'b0);
      run_block(5, 0, 16, 3, 1, 1, 1'b0, 1'b0);
      run_block(1, 1, 15, 0, 1, 2, 1'b0, 1'b0);
      run_block(4, 1, 15, 3, 2, 2, 1'b0, 1'b1);
      run_block(4, 1, 15, 3, 2, 2, 1'b0, 1'b0);
      run_block(5, 2, 4, 0, 1, 2, 1'b0, 1'b0);
`ifdef CAVLC_CTRL_ERR_CHK_EN
      run_block(3, 1, 16, 2, 1, 2, 1'b1, 1'b0);
`endif
      for (int b = 0; b < 40; b++) begin
         case ($urandom_range(0, 2))
            0:       mx = 4;
            1:       mx = 15;
            default: mx = 16;
         endcase
         T  = $urandom_range(0, mx);
         T1 = $urandom_range(0, (T < 3) ? T : 3);
         R  = (T >= 2) ? $urandom_range(1, T - 1) : 0;
         run_block(T, T1, mx, R, $urandom_range(1, 4), 0, 1'b0, 1'b0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
